// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network post-processing stages:
// word width, stage FSM encoding and the common ReLU/clamp arithmetic.
package nn_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } stage_state_t;

    // Negative inputs go to zero; non-negative inputs optionally saturate at clamp_max.
    function automatic logic [DATA_W-1:0] relu_clamp(
        input logic [DATA_W-1:0] x,
        input logic              clamp_en,
        input logic [DATA_W-1:0] clamp_max
    );
        logic [DATA_W-1:0] y;
        if (x[DATA_W-1]) begin
            y = '0;
        end else if (clamp_en && ($signed(x) > $signed(clamp_max))) begin
            y = clamp_max;
        end else begin
            y = x;
        end
        return y;
    endfunction

endpackage

// File: rtl/relu_argmax_stage_if.sv
// Activation beat stream: one neuron value plus its index per valid/ready beat.
interface relu_argmax_stage_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 6
) ();
    logic [DATA_W-1:0] act_data;
    logic [IDX_W-1:0]  act_idx;
    logic              act_valid;
    logic              act_ready;
    logic              act_last;

    modport master (
        output act_data,
        output act_idx,
        output act_valid,
        output act_last,
        input  act_ready
    );

    modport slave (
        input  act_data,
        input  act_idx,
        input  act_valid,
        input  act_last,
        output act_ready
    );
endinterface

// File: rtl/relu_clamp.sv
// Combinational ReLU with optional upper clamp; no width growth.
module relu_clamp #(
    parameter int                DATA_W    = nn_pkg::DATA_W,
    parameter bit                CLAMP_EN  = 1'b0,
    parameter logic [DATA_W-1:0] CLAMP_MAX = DATA_W'(16'h0600)
) (
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y
);

    generate
        if (DATA_W == nn_pkg::DATA_W) begin : g_pkg_fn
            assign y = nn_pkg::relu_clamp(x, CLAMP_EN, CLAMP_MAX);
        end else begin : g_generic
            // Same arithmetic as the package function, for non-default word widths.
            always_comb begin
                y = x;
                if (x[DATA_W-1]) begin
                    y = '0;
                end else if (CLAMP_EN && ($signed(x) > $signed(CLAMP_MAX))) begin
                    y = CLAMP_MAX;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/relu_argmax_stage.sv
// Snapshots the upstream layer vector, streams ReLU-activated neurons one per beat,
// and publishes the activated vector plus the argmax class index.
module relu_argmax_stage
    import nn_pkg::*;
#(
    parameter int                NEURON_COUNT = 50,
    parameter int                DATA_W       = nn_pkg::DATA_W,
    parameter bit                CLAMP_EN     = 1'b0,
    parameter logic [DATA_W-1:0] CLAMP_MAX    = DATA_W'(16'h0600),
    localparam int               IDX_W        = $clog2(NEURON_COUNT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   in_vec [NEURON_COUNT],
    output logic                busy,
    relu_argmax_stage_if.master act,
    output logic [DATA_W-1:0]   out_vec [NEURON_COUNT],
    output logic [IDX_W-1:0]    class_idx,
    output logic [DATA_W-1:0]   class_max,
    output logic                done
);

    stage_state_t state_reg, state_next;

    logic              start_q_reg;
    logic              trigger;
    logic              load;
    logic              handshake;
    logic              last_beat;
    logic              beat_wins;

    logic [DATA_W-1:0] snap_reg    [NEURON_COUNT];
    logic [DATA_W-1:0] out_vec_reg [NEURON_COUNT];
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  max_idx_reg, max_idx_next;
    logic [DATA_W-1:0] max_val_reg, max_val_next;
    logic [IDX_W-1:0]  class_idx_reg;
    logic [DATA_W-1:0] class_max_reg;
    logic [DATA_W-1:0] cur_act;

    // Rising-edge detect so a level-high upstream done fires exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q_reg <= 1'b0;
        end else begin
            start_q_reg <= start;
        end
    end

    assign trigger   = start & ~start_q_reg;
    assign load      = (state_reg == IDLE) & trigger;
    assign handshake = (state_reg == STREAM) & act.act_ready;
    assign last_beat = (idx_reg == IDX_W'(NEURON_COUNT - 1));

    relu_clamp #(
        .DATA_W    (DATA_W),
        .CLAMP_EN  (CLAMP_EN),
        .CLAMP_MAX (CLAMP_MAX)
    ) u_act (
        .x (snap_reg[idx_reg]),
        .y (cur_act)
    );

    // Strict compare keeps the earliest index on ties; max starts at zero so
    // an all-non-positive vector leaves index 0 / value 0.
    assign beat_wins    = $signed(cur_act) > $signed(max_val_reg);
    assign max_idx_next = beat_wins ? idx_reg : max_idx_reg;
    assign max_val_next = beat_wins ? cur_act : max_val_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trigger) state_next = STREAM;
            STREAM:  if (handshake && last_beat) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        act.act_valid = 1'b0;
        act.act_last  = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_reg)
            STREAM: begin
                act.act_valid = 1'b1;
                act.act_last  = last_beat;
                busy          = 1'b1;
            end
            FINISH: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign act.act_data = cur_act;
    assign act.act_idx  = idx_reg;

    // Beat index and running argmax; the result is committed on the last
    // handshake so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg       <= '0;
            max_idx_reg   <= '0;
            max_val_reg   <= '0;
            class_idx_reg <= '0;
            class_max_reg <= '0;
        end else if (load) begin
            idx_reg     <= '0;
            max_idx_reg <= '0;
            max_val_reg <= '0;
        end else if (handshake) begin
            idx_reg     <= last_beat ? '0 : idx_reg + 1'b1;
            max_idx_reg <= max_idx_next;
            max_val_reg <= max_val_next;
            if (last_beat) begin
                class_idx_reg <= max_idx_next;
                class_max_reg <= max_val_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NEURON_COUNT; gi++) begin : g_neuron
            always_ff @(posedge clk) begin
                if (rst) begin
                    snap_reg[gi]    <= '0;
                    out_vec_reg[gi] <= '0;
                end else begin
                    if (load) begin
                        snap_reg[gi] <= in_vec[gi];
                    end
                    if (handshake && (idx_reg == IDX_W'(gi))) begin
                        out_vec_reg[gi] <= cur_act;
                    end
                end
            end
            assign out_vec[gi] = out_vec_reg[gi];
        end
    endgenerate

    assign class_idx = class_idx_reg;
    assign class_max = class_max_reg;

endmodule

// File: tb/tb_relu_argmax_stage.sv
// Directed bench for relu_argmax_stage: a plain DUT and a ReLU6 DUT share stimulus,
// checked every cycle against a vector-level model plus literal per-pass expectations.
module tb_relu_argmax_stage;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic [W-1:0]  in_vec   [N];
    logic [W-1:0]  out_vec0 [N];
    logic [W-1:0]  out_vec1 [N];
    logic [1:0]    busy;
    logic [1:0]    done;
    logic [IW-1:0] class_idx0, class_idx1;
    logic [W-1:0]  class_max0, class_max1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit cmp_en = 1'b0;
    int done_cnt [2];
    int done_cyc [2];
    logic [W-1:0] beats0 [$];
    logic [W-1:0] beats1 [$];

    // Model state: 0 idle, 1 streaming beat m_i, 2 done cycle
    int           m_state = 0;
    int           m_i = 0;
    bit           m_start_q = 1'b0;
    logic [W-1:0] m_snap [N];
    logic [W-1:0] m_out  [2][N];
    int           m_cls  [2];
    logic [W-1:0] m_max  [2];
    int           m_pcls [2];
    logic [W-1:0] m_pmax [2];

    always #5 clk = ~clk;

    relu_argmax_stage_if #(.DATA_W(W), .IDX_W(IW)) if0 ();
    relu_argmax_stage_if #(.DATA_W(W), .IDX_W(IW)) if1 ();
    assign if0.act_ready = ready;
    assign if1.act_ready = ready;

    relu_argmax_stage #(.NEURON_COUNT(N), .DATA_W(W), .CLAMP_EN(1'b0), .CLAMP_MAX(16'h0600)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .busy(busy[0]), .act(if0),
        .out_vec(out_vec0), .class_idx(class_idx0), .class_max(class_max0), .done(done[0])
    );

    relu_argmax_stage #(.NEURON_COUNT(N), .DATA_W(W), .CLAMP_EN(1'b1), .CLAMP_MAX(16'h0600)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .busy(busy[1]), .act(if1),
        .out_vec(out_vec1), .class_idx(class_idx1), .class_max(class_max1), .done(done[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] m_act(input logic [W-1:0] x, input int clamp);
        int s;
        s = int'($signed(x));
        if (s < 0) return '0;
        if (clamp != 0 && s > 'h600) return 16'h0600;
        return x;
    endfunction

    // Argmax from the whole vector: largest activation, then its lowest index.
    task automatic m_argmax(input int clamp, output int ci, output logic [W-1:0] cm);
        int mx;
        mx = 0;
        for (int i = 0; i < N; i++) if (int'(m_act(m_snap[i], clamp)) > mx) mx = int'(m_act(m_snap[i], clamp));
        ci = 0;
        for (int i = N - 1; i >= 0; i--) if (int'(m_act(m_snap[i], clamp)) == mx) ci = i;
        cm = W'(mx);
    endtask

    function automatic vec_t vec4(input logic [W-1:0] a, b, c, d);
        vec_t v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle compare, beat/done capture, then step the model with the inputs
    // the DUT will sample at the coming posedge.
    initial forever begin
        @(negedge clk);
        for (int v = 0; v < 2; v++) begin
            logic          vld, lst;
            logic [W-1:0]  dat, cmx;
            logic [IW-1:0] idx, cid;
            vld = v ? if1.act_valid : if0.act_valid;
            lst = v ? if1.act_last  : if0.act_last;
            dat = v ? if1.act_data  : if0.act_data;
            idx = v ? if1.act_idx   : if0.act_idx;
            cid = v ? class_idx1    : class_idx0;
            cmx = v ? class_max1    : class_max0;
            if (cmp_en) begin
                chk($sformatf("act_valid[%0d]", v), 32'(vld), 32'(m_state == 1));
                if (m_state == 1) begin
                    chk($sformatf("act_data[%0d]", v), 32'(dat), 32'(m_act(m_snap[m_i], v)));
                    chk($sformatf("act_idx[%0d]", v), 32'(idx), 32'(m_i));
                    chk($sformatf("act_last[%0d]", v), 32'(lst), 32'(m_i == N - 1));
                end
                chk($sformatf("busy[%0d]", v), 32'(busy[v]), 32'(m_state != 0));
                chk($sformatf("done[%0d]", v), 32'(done[v]), 32'(m_state == 2));
                chk($sformatf("class_idx[%0d]", v), 32'(cid), 32'(m_cls[v]));
                chk($sformatf("class_max[%0d]", v), 32'(cmx), 32'(m_max[v]));
                for (int i = 0; i < N; i++)
                    chk($sformatf("out_vec[%0d][%0d]", v, i), 32'(v ? out_vec1[i] : out_vec0[i]), 32'(m_out[v][i]));
            end
            if (vld && ready) begin
                if (v == 0) beats0.push_back(dat); else beats1.push_back(dat);
            end
            if (done[v]) begin
                done_cnt[v]++;
                done_cyc[v] = cyc;
            end
        end
        if (rst) begin
            m_state = 0; m_i = 0; m_start_q = 1'b0;
            for (int v = 0; v < 2; v++) begin
                m_cls[v] = 0; m_max[v] = '0;
                for (int i = 0; i < N; i++) m_out[v][i] = '0;
            end
        end else begin
            bit trig;
            trig = start && !m_start_q;
            m_start_q = start;
            case (m_state)
                0: if (trig) begin
                    for (int i = 0; i < N; i++) m_snap[i] = in_vec[i];
                    m_i = 0;
                    m_state = 1;
                    for (int v = 0; v < 2; v++) m_argmax(v, m_pcls[v], m_pmax[v]);
                end
                1: if (ready) begin
                    for (int v = 0; v < 2; v++) m_out[v][m_i] = m_act(m_snap[m_i], v);
                    if (m_i == N - 1) begin
                        m_state = 2;
                        for (int v = 0; v < 2; v++) begin
                            m_cls[v] = m_pcls[v];
                            m_max[v] = m_pmax[v];
                        end
                    end else begin
                        m_i++;
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    task automatic run_pass(input string name, input vec_t v, input int stall, input int hold,
                            input vec_t eb0, input int c0, input logic [W-1:0] cm0,
                            input vec_t eb1, input int c1, input logic [W-1:0] cm1);
        int t0, dn0, dn1;
        @(posedge clk); #2;
        for (int i = 0; i < N; i++) in_vec[i] = v[i];
        beats0.delete();
        beats1.delete();
        dn0 = done_cnt[0];
        dn1 = done_cnt[1];
        start = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #2;
            start = (k < hold);
            ready = !(k >= 2 && k < 2 + stall);
            if (k == 1) for (int i = 0; i < N; i++) in_vec[i] = ~v[i];
            if (k > hold + 1 && done_cnt[0] > dn0 && done_cnt[1] > dn1) break;
        end
        start = 1'b0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({name, " done_count0"}, 32'(done_cnt[0] - dn0), 32'd1);
        chk({name, " done_count1"}, 32'(done_cnt[1] - dn1), 32'd1);
        chk({name, " done_latency0"}, 32'(done_cyc[0] - t0), 32'(N + 1 + stall));
        chk({name, " done_latency1"}, 32'(done_cyc[1] - t0), 32'(N + 1 + stall));
        chk({name, " beats0"}, 32'(beats0.size()), 32'(N));
        chk({name, " beats1"}, 32'(beats1.size()), 32'(N));
        for (int i = 0; i < N && i < beats0.size(); i++) chk($sformatf("%s beat0[%0d]", name, i), 32'(beats0[i]), 32'(eb0[i]));
        for (int i = 0; i < N && i < beats1.size(); i++) chk($sformatf("%s beat1[%0d]", name, i), 32'(beats1[i]), 32'(eb1[i]));
        chk({name, " class_idx0"}, 32'(class_idx0), 32'(c0));
        chk({name, " class_max0"}, 32'(class_max0), 32'(cm0));
        chk({name, " class_idx1"}, 32'(class_idx1), 32'(c1));
        chk({name, " class_max1"}, 32'(class_max1), 32'(cm1));
        $display("[TB] pass %s done: class %0d/%0d max %h/%h", name, class_idx0, class_idx1, class_max0, class_max1);
    endtask

    initial begin
        int dn0;
        vec_t v;
        for (int i = 0; i < N; i++) in_vec[i] = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset act_valid", 32'({if1.act_valid, if0.act_valid}), 32'd0);
        chk("reset act_last", 32'({if1.act_last, if0.act_last}), 32'd0);
        chk("reset act_data", 32'(if0.act_data), 32'd0);
        chk("reset act_idx", 32'(if0.act_idx), 32'd0);
        chk("reset class_idx", 32'(class_idx0), 32'd0);
        chk("reset class_max", 32'(class_max0), 32'd0);
        chk("reset out_vec", 32'(out_vec0[2] | out_vec1[3]), 32'd0);

        v = vec4(16'h0100, 16'hFF00, 16'h0300, 16'h0200);
        run_pass("basic", v, 0, 1, vec4(16'h0100, 16'h0000, 16'h0300, 16'h0200), 2, 16'h0300,
                 vec4(16'h0100, 16'h0000, 16'h0300, 16'h0200), 2, 16'h0300);
        chk("basic out_vec0[2]", 32'(out_vec0[2]), 32'h0300);

        run_pass("ties", vec4(16'h0200, 16'h0500, 16'h0500, 16'h0100), 0, 1,
                 vec4(16'h0200, 16'h0500, 16'h0500, 16'h0100), 1, 16'h0500,
                 vec4(16'h0200, 16'h0500, 16'h0500, 16'h0100), 1, 16'h0500);

        run_pass("negative", vec4(16'h8000, 16'hFFFF, 16'hFE00, 16'hFF80), 0, 1,
                 vec4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 0, 16'h0000,
                 vec4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 0, 16'h0000);

        run_pass("clamp", vec4(16'h0800, 16'h0500, 16'h7FFF, 16'h0600), 0, 1,
                 vec4(16'h0800, 16'h0500, 16'h7FFF, 16'h0600), 2, 16'h7FFF,
                 vec4(16'h0600, 16'h0500, 16'h0600, 16'h0600), 0, 16'h0600);

        run_pass("stall", vec4(16'h0100, 16'h0400, 16'h0050, 16'h0400), 3, 1,
                 vec4(16'h0100, 16'h0400, 16'h0050, 16'h0400), 1, 16'h0400,
                 vec4(16'h0100, 16'h0400, 16'h0050, 16'h0400), 1, 16'h0400);

        run_pass("hold", vec4(16'h0000, 16'h0700, 16'h0300, 16'h0700), 0, 10,
                 vec4(16'h0000, 16'h0700, 16'h0300, 16'h0700), 1, 16'h0700,
                 vec4(16'h0000, 16'h0600, 16'h0300, 16'h0600), 1, 16'h0600);

        // Reset while beat 2 is presented aborts the pass.
        @(posedge clk); #2;
        for (int i = 0; i < N; i++) in_vec[i] = v[i];
        dn0 = done_cnt[0];
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid pre act_idx", 32'(if0.act_idx), 32'd2);
        @(negedge clk);
        chk("rst_mid act_valid", 32'({if1.act_valid, if0.act_valid}), 32'd0);
        chk("rst_mid out_vec0[0]", 32'(out_vec0[0]), 32'd0);
        chk("rst_mid out_vec1[0]", 32'(out_vec1[0]), 32'd0);
        chk("rst_mid out_vec0[1]", 32'(out_vec0[1]), 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("rst_mid no done", 32'(done_cnt[0] - dn0), 32'd0);
        $display("[TB] reset mid-stream done");

        run_pass("after_rst", vec4(16'h0050, 16'h0020, 16'h0060, 16'h0010), 0, 1,
                 vec4(16'h0050, 16'h0020, 16'h0060, 16'h0010), 2, 16'h0060,
                 vec4(16'h0050, 16'h0020, 16'h0060, 16'h0010), 2, 16'h0060);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
